// File: rtl/mux8.sv
// mux8: eight-way data selector with a combinational view of the selected input
// and a registered, enable-gated capture of that selection.
module mux8 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  logic [WIDTH-1:0] d4,
    input  logic [WIDTH-1:0] d5,
    input  logic [WIDTH-1:0] d6,
    input  logic [WIDTH-1:0] d7,
    input  logic [2:0]       sel,
    input  logic             en,
    output logic [WIDTH-1:0] out,
    output logic [2:0]       out_sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] mux_comb
);

    logic [WIDTH-1:0] out_q;
    logic [2:0]       out_sel_q;
    logic             out_valid_q;

    // Select d[sel]; all eight codes are decoded, so no latch can form.
    always_comb begin
        mux_comb = '0;
        unique case (sel)
            3'd0: mux_comb = d0;
            3'd1: mux_comb = d1;
            3'd2: mux_comb = d2;
            3'd3: mux_comb = d3;
            3'd4: mux_comb = d4;
            3'd5: mux_comb = d5;
            3'd6: mux_comb = d6;
            3'd7: mux_comb = d7;
            default: mux_comb = '0;
        endcase
    end

    // Capture the selection on enabled edges; reset clears everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= '0;
            out_sel_q   <= 3'd0;
            out_valid_q <= 1'b0;
        end else if (en) begin
            out_q       <= mux_comb;
            out_sel_q   <= sel;
            out_valid_q <= 1'b1;
        end
    end

    assign out       = out_q;
    assign out_sel   = out_sel_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux8.sv
// Directed testbench for mux8: WIDTH=8 main instance plus WIDTH=1 and WIDTH=64
// instances sharing clock, reset, sel and en.
module tb_mux8;

    logic        clk;
    logic        rst_n;
    logic [2:0]  sel;
    logic        en;

    logic [7:0]  d8  [8];
    logic [0:0]  d1  [8];
    logic [63:0] d64 [8];

    logic [7:0]  out8,  comb8;
    logic [0:0]  out1,  comb1;
    logic [63:0] out64, comb64;
    logic [2:0]  osel8, osel1, osel64;
    logic        vld8, vld1, vld64;

    int checks = 0;
    int errors = 0;

    mux8 #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .d0(d8[0]), .d1(d8[1]), .d2(d8[2]), .d3(d8[3]),
        .d4(d8[4]), .d5(d8[5]), .d6(d8[6]), .d7(d8[7]),
        .sel(sel), .en(en),
        .out(out8), .out_sel(osel8), .out_valid(vld8), .mux_comb(comb8)
    );

    mux8 #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .d0(d1[0]), .d1(d1[1]), .d2(d1[2]), .d3(d1[3]),
        .d4(d1[4]), .d5(d1[5]), .d6(d1[6]), .d7(d1[7]),
        .sel(sel), .en(en),
        .out(out1), .out_sel(osel1), .out_valid(vld1), .mux_comb(comb1)
    );

    mux8 #(.WIDTH(64)) dut64 (
        .clk(clk), .rst_n(rst_n),
        .d0(d64[0]), .d1(d64[1]), .d2(d64[2]), .d3(d64[3]),
        .d4(d64[4]), .d5(d64[5]), .d6(d64[6]), .d7(d64[7]),
        .sel(sel), .en(en),
        .out(out64), .out_sel(osel64), .out_valid(vld64), .mux_comb(comb64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0]  p1;
        logic [63:0] p64;
        p1  = 8'b1011_0010;
        p64 = 64'hA5A5_A5A5_A5A5_A5A5;
        for (int i = 0; i < 8; i++) begin
            d8[i]  = 8'(i + 10);
            d1[i]  = p1[i];
            d64[i] = p64 ^ (64'(i + 1) << (i * 8));
        end
        rst_n = 1'b0;
        en    = 1'b0;
        sel   = 3'd2;
        #1;
        check("rst_out",   64'(out8),  64'd0);
        check("rst_sel",   64'(osel8), 64'd0);
        check("rst_valid", 64'(vld8),  64'd0);
        check("rst_comb",  64'(comb8), 64'd12);

        // Clocks and en are ignored while reset is held.
        en = 1'b1;
        tick();
        tick();
        check("rst_hold_out",   64'(out8), 64'd0);
        check("rst_hold_valid", 64'(vld8), 64'd0);

        // Release between edges; first edge after release captures.
        #3;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sel = 3'(i);
            en  = 1'b1;
            #1;
            check("sweep_comb8",  64'(comb8), 64'(i + 10));
            check("sweep_comb1",  64'(comb1), 64'(p1[i]));
            check("sweep_comb64", comb64,     p64 ^ (64'(i + 1) << (i * 8)));
            tick();
            check("sweep_out8",  64'(out8),  64'(i + 10));
            check("sweep_sel8",  64'(osel8), 64'(i));
            check("sweep_vld8",  64'(vld8),  64'd1);
            check("sweep_out1",  64'(out1),  64'(p1[i]));
            check("sweep_out64", out64,      p64 ^ (64'(i + 1) << (i * 8)));
        end

        // Capture sel=0, then hold with en=0 while sel moves.
        sel = 3'd0;
        tick();
        check("reload_out", 64'(out8), 64'd10);
        en  = 1'b0;
        sel = 3'd5;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("hold_out",  64'(out8),  64'd10);
            check("hold_sel",  64'(osel8), 64'd0);
            check("hold_comb", 64'(comb8), 64'd15);
        end

        // Only the value present at the edge is captured.
        en    = 1'b1;
        sel   = 3'd2;
        d8[2] = 8'h55;
        @(posedge clk);
        #1;
        d8[2] = 8'h66;
        en    = 1'b0;
        #3;
        check("edge_sample", 64'(out8), 64'h55);
        d8[2] = 8'd12;

        // Mid-cycle reset clears out at once.
        en  = 1'b1;
        sel = 3'd7;
        tick();
        check("pre_rst_out", 64'(out8), 64'd17);
        en = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        check("async_out",   64'(out8),  64'd0);
        check("async_sel",   64'(osel8), 64'd0);
        check("async_valid", 64'(vld8),  64'd0);
        #1;
        rst_n = 1'b1;
        en    = 1'b1;
        sel   = 3'd3;
        tick();
        check("post_rst_out",   64'(out8), 64'd13);
        check("post_rst_valid", 64'(vld8), 64'd1);

        // d0 all ones, others zero, alternating sel.
        for (int i = 0; i < 8; i++) d8[i] = 8'h00;
        d8[0] = 8'hFF;
        for (int k = 0; k < 6; k++) begin
            sel = 3'(k % 2);
            tick();
            check("alt_out", 64'(out8), (k % 2 == 0) ? 64'hFF : 64'h00);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
